mantenimiento_fsm_param: RTL and testbench
==========================================

// Module: mantenimiento_fsm_param
// PURPOSE
//  Parametrised maintenance sequencer, successor of the fixed 8-bit maintenance FSM.
//  - Runs a maintenance job as NUM_FASES consecutive phases of programmable length.
//  - Supports pause and abort, and keeps a saturating count of completed jobs.
//  - Sits under the system controller, which drives iniciar/detener/pausa and reads status.
// PARAMETERS
//  NUM_FASES  4  number of phases per job (>=2)
//  DUR_W      8  width of per-phase duration, in clock cycles
//  CNT_W      8  width of completed-job counter
//  ESTADO_W   8  width of estado output (zero-extended state code)
// PORTS
//  clk                 in   1                     single clock, rising edge
//  reset_n             in   1                     asynchronous active-low reset
//  iniciar             in   1                     start request (level, sampled each cycle)
//  detener             in   1                     abort request; highest priority after reset
//  pausa               in   1                     freeze while high
//  duracion            in   DUR_W                 cycles per phase, latched on accepted start
//  estado              out  ESTADO_W              state code: IDLE=0 FASE=1 PAUSA=2 FIN=3 ABORTO=4
//  fase                out  $clog2(NUM_FASES)     current phase index
//  num_mantenimientos  out  CNT_W                 completed jobs, saturating
//  ocupado             out  1                     high in FASE or PAUSA
//  terminado           out  1                     1-cycle pulse, job completed
//  abortado            out  1                     1-cycle pulse, job aborted
// BEHAVIOUR
//  - All outputs are registered. On reset_n=0, asynchronously:
//    - state=IDLE; estado=0, fase=0, num_mantenimientos=0.
//    - ocupado=0, terminado=0, abortado=0; internal cycle counter=0.
//  - IDLE:
//    - iniciar=1, detener=0 and duracion!=0 -> latch duracion, fase=0, cnt=0; FASE at next edge.
//    - duracion==0 -> request ignored, stay IDLE.
//    - iniciar and detener both high -> stay IDLE.
//  - FASE, each cycle:
//    - If cnt==dur_lat-1: cnt=0 and fase++.
//    - If that was the last phase (fase==NUM_FASES-1): fase stays, next state FIN.
//    - Otherwise cnt++.
//    - Total FASE cycles per job = NUM_FASES*dur_lat.
//  - pausa=1 in FASE -> PAUSA at next edge; cnt and fase frozen.
//  - pausa=0 in PAUSA -> FASE at next edge, resuming from the frozen count.
//  - A paused cycle is not counted toward the phase.
//  - detener=1 in FASE or PAUSA -> ABORTO at next edge; it wins over pausa and over phase completion.
//  - ABORTO lasts one cycle:
//    - abortado=1; counter unchanged.
//    - fase=0, cnt=0; then IDLE.
//  - FIN lasts one cycle:
//    - terminado=1; num_mantenimientos += 1, holding at 2**CNT_W-1 (no wrap).
//    - fase=0; then IDLE.
//  - detener in IDLE/FIN/ABORTO: no effect. iniciar outside IDLE: ignored, not queued.
//  - Changes to duracion after the job is accepted are ignored until the next start.
//  - Latency:
//    - iniciar accepted at edge k -> estado=FASE after edge k.
//    - terminado is high during the cycle after the last FASE cycle.
//  - Reset mid-job aborts immediately with no abortado pulse.
// CONFIGURATION
//  MANT_AUTO_REPETIR_EN defined:
//    - Adds input port repetir (1 bit).
//    - In FIN with repetir=1 and detener=0: next state FASE, fase=0, same dur_lat.
//    - terminado still pulses and the counter still increments.
//  MANT_AUTO_REPETIR_EN undefined:
//    - Port repetir is absent; FIN always goes to IDLE.
// TESTING (NUM_FASES=4, DUR_W=8, CNT_W=8 unless stated)
//  1. duracion=3, iniciar 1 cycle -> 12 cycles ocupado=1, fase 0..3 three cycles each,
//     then terminado 1 cycle, num_mantenimientos=1, estado=0.
//  2. duracion=3, pausa high 5 cycles during fase 1 -> estado=2 for 5 cycles,
//     fase/cnt frozen, terminado 17 cycles after start instead of 12.
//  3. duracion=4, detener during fase 2 -> estado=4 one cycle, abortado=1,
//     num_mantenimientos unchanged, then IDLE; next start begins at fase 0.
//  4. CNT_W=2, five complete jobs with duracion=1 -> num_mantenimientos 1,2,3,3,3.
//  5. duracion=0 with iniciar -> stays IDLE; iniciar+detener same cycle -> stays IDLE;
//     iniciar during FASE -> ignored.
//  6. reset_n low mid-fase 1 -> all outputs 0 immediately, no terminado/abortado;
//     with MANT_AUTO_REPETIR_EN, repetir=1, duracion=2 -> back-to-back jobs, terminado every 9 cycles.

Source files
------------

// File: rtl/mantenimiento_fsm_param.sv
// rtl/mantenimiento_fsm_param.sv - parametrised maintenance sequencer: NUM_FASES timed phases, pause, abort, job counter
// Build option MANT_AUTO_REPETIR_EN adds input repetir, which restarts the job straight from FIN.
module mantenimiento_fsm_param #(
  parameter int NUM_FASES = 4,
  parameter int DUR_W     = 8,
  parameter int CNT_W     = 8,
  parameter int ESTADO_W  = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         iniciar,
  input  logic                         detener,
  input  logic                         pausa,
`ifdef MANT_AUTO_REPETIR_EN
  input  logic                         repetir,
`endif
  input  logic [DUR_W-1:0]             duracion,
  output logic [ESTADO_W-1:0]          estado,
  output logic [$clog2(NUM_FASES)-1:0] fase,
  output logic [CNT_W-1:0]             num_mantenimientos,
  output logic                         ocupado,
  output logic                         terminado,
  output logic                         abortado
);

  localparam int FASE_W = $clog2(NUM_FASES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FASE   = 3'd1,
    S_PAUSA  = 3'd2,
    S_FIN    = 3'd3,
    S_ABORTO = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [DUR_W-1:0]    cnt_q, cnt_d;
  logic [FASE_W-1:0]   fase_q, fase_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic                ocupado_q, ocupado_d;
  logic                terminado_q, terminado_d;
  logic                abortado_q, abortado_d;
  logic                fin_fase;
  logic                ultima_fase;

  assign fin_fase    = (cnt_q == dur_q - DUR_W'(1));
  assign ultima_fase = (fase_q == FASE_W'(NUM_FASES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      dur_q       <= '0;
      cnt_q       <= '0;
      fase_q      <= '0;
      num_q       <= '0;
      ocupado_q   <= 1'b0;
      terminado_q <= 1'b0;
      abortado_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dur_q       <= dur_d;
      cnt_q       <= cnt_d;
      fase_q      <= fase_d;
      num_q       <= num_d;
      ocupado_q   <= ocupado_d;
      terminado_q <= terminado_d;
      abortado_q  <= abortado_d;
    end
  end

  // Abort outranks everything; a finishing job outranks a pause request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (iniciar && !detener && (duracion != '0)) state_d = S_FASE;
      end
      S_FASE: begin
        if (detener)                      state_d = S_ABORTO;
        else if (fin_fase && ultima_fase) state_d = S_FIN;
        else if (pausa)                   state_d = S_PAUSA;
      end
      S_PAUSA: begin
        if (detener)     state_d = S_ABORTO;
        else if (!pausa) state_d = S_FASE;
      end
      S_FIN: begin
`ifdef MANT_AUTO_REPETIR_EN
        if (repetir && !detener) state_d = S_FASE;
        else                     state_d = S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      S_ABORTO: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // The FASE cycle that requests a pause still counts; only PAUSA cycles are frozen.
  always_comb begin
    dur_d  = dur_q;
    cnt_d  = cnt_q;
    fase_d = fase_q;
    num_d  = num_q;
    case (state_q)
      S_IDLE: begin
        if (state_d == S_FASE) begin
          dur_d  = duracion;
          cnt_d  = '0;
          fase_d = '0;
        end
      end
      S_FASE: begin
        if (state_d == S_ABORTO) begin
          cnt_d  = '0;
          fase_d = '0;
        end else if (fin_fase) begin
          cnt_d = '0;
          if (!ultima_fase) fase_d = fase_q + FASE_W'(1);
        end else begin
          cnt_d = cnt_q + DUR_W'(1);
        end
      end
      S_PAUSA: begin
        if (state_d == S_ABORTO) begin
          cnt_d  = '0;
          fase_d = '0;
        end
      end
      default: begin
        cnt_d  = '0;
        fase_d = '0;
      end
    endcase
    if ((state_d == S_FIN) && (num_q != {CNT_W{1'b1}})) num_d = num_q + CNT_W'(1);
    ocupado_d   = (state_d == S_FASE) || (state_d == S_PAUSA);
    terminado_d = (state_d == S_FIN);
    abortado_d  = (state_d == S_ABORTO);
  end

  assign estado             = ESTADO_W'(state_q);
  assign fase               = fase_q;
  assign num_mantenimientos = num_q;
  assign ocupado            = ocupado_q;
  assign terminado          = terminado_q;
  assign abortado           = abortado_q;

endmodule

// File: tb/tb_mantenimiento_fsm_param.sv
// tb/tb_mantenimiento_fsm_param.sv - scoreboard bench for mantenimiento_fsm_param
// Optional MANT_AUTO_REPETIR_EN build also exercises back-to-back auto-repeat jobs.
module tb_mantenimiento_fsm_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, iniciar, detener, pausa;
  logic [7:0] duracion;
  logic [7:0] estado;
  logic [1:0] fase;
  logic [7:0] num;
  logic       ocupado, terminado, abortado;

  logic       iniciar2;
  logic [7:0] duracion2;
  logic [7:0] estado2;
  logic [1:0] fase2;
  logic [1:0] num2;
  logic       ocupado2, terminado2, abortado2;
`ifdef MANT_AUTO_REPETIR_EN
  logic       repetir;
  logic       repetir2;
`endif

  mantenimiento_fsm_param u_dut (
    .clk(clk), .reset_n(reset_n), .iniciar(iniciar), .detener(detener), .pausa(pausa),
`ifdef MANT_AUTO_REPETIR_EN
    .repetir(repetir),
`endif
    .duracion(duracion), .estado(estado), .fase(fase), .num_mantenimientos(num),
    .ocupado(ocupado), .terminado(terminado), .abortado(abortado)
  );

  mantenimiento_fsm_param #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .iniciar(iniciar2), .detener(1'b0), .pausa(1'b0),
`ifdef MANT_AUTO_REPETIR_EN
    .repetir(repetir2),
`endif
    .duracion(duracion2), .estado(estado2), .fase(fase2), .num_mantenimientos(num2),
    .ocupado(ocupado2), .terminado(terminado2), .abortado(abortado2)
  );

  typedef struct packed {
    logic [7:0] estado;
    logic [1:0] fase;
    logic       ocupado;
    logic       terminado;
    logic       abortado;
  } obs_t;

  typedef struct packed {
    obs_t v;
    logic fase_any;
  } exp_t;

  exp_t exp_q[$];
  int   num2_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  obs_t obs;

  always_comb obs = {estado, fase, ocupado, terminado, abortado};

  function automatic exp_t mk(input int e, input int f, input bit o, input bit t, input bit a,
                              input bit any = 1'b0);
    exp_t r;
    r.v.estado    = 8'(e);
    r.v.fase      = 2'(f);
    r.v.ocupado   = o;
    r.v.terminado = t;
    r.v.abortado  = a;
    r.fase_any    = any;
    return r;
  endfunction

  task automatic test_reset();
    reset_n = 1'b1; iniciar = 1'b0; detener = 1'b0; pausa = 1'b0; duracion = 8'd0;
    iniciar2 = 1'b0; duracion2 = 8'd0;
`ifdef MANT_AUTO_REPETIR_EN
    repetir = 1'b0; repetir2 = 1'b0;
`endif
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %b expected %b", obs, 13'b0);
    end
    n_cmp++;
    if (num !== 8'd0 || num2 !== 2'd0) begin
      n_err++; $display("FAIL reset_counter: got %0d/%0d expected 0/0", num, num2);
    end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (obs !== '0) begin
      n_err++; $display("FAIL reset_idle: got %b expected %b", obs, 13'b0);
    end
  endtask

  task automatic test_job_completo();
    exp_t x; obs_t o;
    duracion = 8'd3;
    for (int c = 0; c < 12; c++) exp_q.push_back(mk(1, c / 3, 1, 0, 0));
    exp_q.push_back(mk(3, 3, 0, 1, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    for (int c = 0; c < 14; c++) begin
      iniciar = (c == 0);
      if (c == 1) duracion = 8'd7;
      @(posedge clk); #1;
      x = exp_q.pop_front(); o = obs;
      if (x.fase_any) o.fase = x.v.fase;
      n_cmp++;
      if (o !== x.v) begin
        n_err++; $display("FAIL job_completo c=%0d: got %b expected %b", c, o, x.v);
      end
    end
    n_cmp++;
    if (num !== 8'd1) begin
      n_err++; $display("FAIL job_completo_num: got %0d expected 1", num);
    end
  endtask

  task automatic test_pausa();
    exp_t x; obs_t o;
    duracion = 8'd3;
    for (int c = 0; c < 19; c++) begin
      int j;
      j = (c < 5) ? c : c - 5;
      if (c >= 5 && c <= 9) exp_q.push_back(mk(2, 1, 1, 0, 0));
      else if (j < 12)      exp_q.push_back(mk(1, j / 3, 1, 0, 0));
      else if (j == 12)     exp_q.push_back(mk(3, 3, 0, 1, 0));
      else                  exp_q.push_back(mk(0, 0, 0, 0, 0));
    end
    for (int c = 0; c < 19; c++) begin
      iniciar = (c == 0);
      pausa   = (c >= 5 && c <= 9);
      @(posedge clk); #1;
      x = exp_q.pop_front(); o = obs;
      if (x.fase_any) o.fase = x.v.fase;
      n_cmp++;
      if (o !== x.v) begin
        n_err++; $display("FAIL pausa c=%0d: got %b expected %b", c, o, x.v);
      end
    end
    pausa = 1'b0;
    n_cmp++;
    if (num !== 8'd2) begin
      n_err++; $display("FAIL pausa_num: got %0d expected 2", num);
    end
  endtask

  task automatic test_aborto();
    exp_t x; obs_t o;
    duracion = 8'd4;
    for (int c = 0; c < 10; c++) exp_q.push_back(mk(1, c / 4, 1, 0, 0));
    exp_q.push_back(mk(4, 0, 0, 0, 1, 1'b1));
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    for (int c = 0; c < 12; c++) begin
      iniciar = (c == 0);
      detener = (c == 10);
      @(posedge clk); #1;
      x = exp_q.pop_front(); o = obs;
      if (x.fase_any) o.fase = x.v.fase;
      n_cmp++;
      if (o !== x.v) begin
        n_err++; $display("FAIL aborto c=%0d: got %b expected %b", c, o, x.v);
      end
    end
    detener = 1'b0;
    n_cmp++;
    if (num !== 8'd2) begin
      n_err++; $display("FAIL aborto_num: got %0d expected 2", num);
    end
    duracion = 8'd1;
    for (int c = 0; c < 4; c++) exp_q.push_back(mk(1, c, 1, 0, 0));
    exp_q.push_back(mk(3, 3, 0, 1, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    for (int c = 0; c < 6; c++) begin
      iniciar = (c == 0);
      @(posedge clk); #1;
      x = exp_q.pop_front(); o = obs;
      if (x.fase_any) o.fase = x.v.fase;
      n_cmp++;
      if (o !== x.v) begin
        n_err++; $display("FAIL aborto_restart c=%0d: got %b expected %b", c, o, x.v);
      end
    end
    n_cmp++;
    if (num !== 8'd3) begin
      n_err++; $display("FAIL aborto_restart_num: got %0d expected 3", num);
    end
  endtask

  task automatic test_peticiones_ignoradas();
    exp_t x; obs_t o;
    for (int c = 0; c < 5; c++) exp_q.push_back(mk(0, 0, 0, 0, 0));
    for (int c = 0; c < 8; c++) exp_q.push_back(mk(1, c / 2, 1, 0, 0));
    exp_q.push_back(mk(3, 3, 0, 1, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    for (int c = -5; c < 11; c++) begin
      if (c < -2) begin
        duracion = 8'd0; iniciar = 1'b1; detener = 1'b0;
      end else if (c < 0) begin
        duracion = 8'd5; iniciar = 1'b1; detener = 1'b1;
      end else begin
        duracion = 8'd2;
        iniciar  = (c <= 4) || (c == 9);
        detener  = (c == 9);
      end
      @(posedge clk); #1;
      x = exp_q.pop_front(); o = obs;
      if (x.fase_any) o.fase = x.v.fase;
      n_cmp++;
      if (o !== x.v) begin
        n_err++; $display("FAIL ignoradas c=%0d: got %b expected %b", c, o, x.v);
      end
    end
    iniciar = 1'b0; detener = 1'b0;
    n_cmp++;
    if (num !== 8'd4) begin
      n_err++; $display("FAIL ignoradas_num: got %0d expected 4", num);
    end
  endtask

  task automatic test_saturacion();
    int e;
    bit saw_t;
    duracion2 = 8'd1;
    for (int j = 0; j < 5; j++) num2_q.push_back((j + 1 > 3) ? 3 : j + 1);
    for (int j = 0; j < 5; j++) begin
      saw_t = 1'b0;
      for (int c = 0; c < 6; c++) begin
        iniciar2 = (c == 0);
        @(posedge clk); #1;
        if (terminado2) saw_t = 1'b1;
      end
      e = num2_q.pop_front();
      n_cmp++;
      if (num2 !== 2'(e) || !saw_t) begin
        n_err++; $display("FAIL saturacion job=%0d: got num=%0d term_seen=%0d expected num=%0d term_seen=1",
                          j, num2, saw_t, e);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    exp_t x; obs_t o;
    duracion = 8'd3;
    for (int c = 0; c < 5; c++) exp_q.push_back(mk(1, c / 3, 1, 0, 0));
    for (int c = 0; c < 5; c++) begin
      iniciar = (c == 0);
      @(posedge clk); #1;
      x = exp_q.pop_front(); o = obs;
      n_cmp++;
      if (o !== x.v) begin
        n_err++; $display("FAIL reset_mid_pre c=%0d: got %b expected %b", c, o, x.v);
      end
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== '0 || num !== 8'd0) begin
      n_err++; $display("FAIL reset_mid_async: got %b num=%0d expected %b num=0", obs, num, 13'b0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 15; c++) exp_q.push_back(mk(0, 0, 0, 0, 0));
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      x = exp_q.pop_front(); o = obs;
      n_cmp++;
      if (o !== x.v) begin
        n_err++; $display("FAIL reset_mid_post c=%0d: got %b expected %b", c, o, x.v);
      end
    end
  endtask

`ifdef MANT_AUTO_REPETIR_EN
  task automatic test_back_to_back();
    exp_t x; obs_t o;
    duracion = 8'd2;
    for (int c = 0; c < 27; c++) begin
      if (c % 9 == 8) exp_q.push_back(mk(3, 3, 0, 1, 0));
      else            exp_q.push_back(mk(1, (c % 9) / 2, 1, 0, 0));
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    for (int c = 0; c < 28; c++) begin
      iniciar = (c == 0);
      repetir = (c < 27);
      @(posedge clk); #1;
      x = exp_q.pop_front(); o = obs;
      n_cmp++;
      if (o !== x.v) begin
        n_err++; $display("FAIL back_to_back c=%0d: got %b expected %b", c, o, x.v);
      end
    end
    repetir = 1'b0;
    n_cmp++;
    if (num !== 8'd3) begin
      n_err++; $display("FAIL back_to_back_num: got %0d expected 3", num);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_job_completo();
    test_pausa();
    test_aborto();
    test_peticiones_ignoradas();
    test_saturacion();
    test_reset_mid_job();
`ifdef MANT_AUTO_REPETIR_EN
    test_back_to_back();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
